// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg
// Shared definitions for the HC-SR04 ranging blocks on the car:
//   - state_t        : one-hot state encoding of the trigger sequencer
//   - cycles_us/ms   : convert a duration into clock cycles at a given clock rate
//   - CLK_FREQ_HZ    : default system clock, shared with the echo measurement stage
//   - US_PER_CM      : echo round-trip time per centimetre of range
package ultrasonic_pkg;

  localparam int unsigned CLK_FREQ_HZ = 125_000_000;
  localparam int unsigned US_PER_CM   = 58;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_TRIG      = 5'b00010,
    S_WAIT_RISE = 5'b00100,
    S_WAIT_FALL = 5'b01000,
    S_HOLD      = 5'b10000
  } state_t;

  // The clock rate is divided first so the product stays inside 32 bits
  // for every clock/duration combination used on the car.
  function automatic int unsigned cycles_us(input int unsigned clk_hz,
                                            input int unsigned us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

  function automatic int unsigned cycles_ms(input int unsigned clk_hz,
                                            input int unsigned ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for asynchronous single-bit inputs. Both flops reset
// to 0 so the synchronised level is defined while rst_n is low.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronised output, two clk cycles behind d
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ultrasonic_trig.sv
// ultrasonic_trig
// Trigger sequencer for the HC-SR04 ranger. Issues the trigger pulse either
// periodically (en) or on a single request (start), forwards the synchronised
// echo to the width measurement stage and flags completion or timeout.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   en      - periodic ranging enable
//   start   - single-shot request, only looked at in IDLE
//   echo    - raw asynchronous echo pin
//   trig    - registered sensor trigger
//   echo_q  - echo after the 2-flop synchroniser
//   busy    - high whenever the sequencer is not in IDLE
//   done    - one-cycle pulse on the echo falling edge
//   timeout - one-cycle pulse when no echo completed in time
// Build option: define ULTRASONIC_TIMEOUT_EN to build the echo timeout.
// Without it the wait states wait forever and timeout is tied low.
module ultrasonic_trig #(
  parameter int unsigned CLK_FREQ_HZ = ultrasonic_pkg::CLK_FREQ_HZ,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned PERIOD_MS   = 60,
  parameter int unsigned TIMEOUT_MS  = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic start,
  input  logic echo,
  output logic trig,
  output logic echo_q,
  output logic busy,
  output logic done,
  output logic timeout
);

  import ultrasonic_pkg::*;

  localparam int unsigned TRIG_CYC   = cycles_us(CLK_FREQ_HZ, TRIG_US);
  localparam int unsigned PERIOD_CYC = cycles_ms(CLK_FREQ_HZ, PERIOD_MS);
  localparam int unsigned TO_CYC     = cycles_ms(CLK_FREQ_HZ, TIMEOUT_MS);

  localparam int unsigned MAX_CYC =
    (TRIG_CYC > PERIOD_CYC) ? ((TRIG_CYC > TO_CYC) ? TRIG_CYC : TO_CYC)
                            : ((PERIOD_CYC > TO_CYC) ? PERIOD_CYC : TO_CYC);
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] trig_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             echo_prev;
  logic             armed;
  logic             echo_rise;
  logic             echo_fall;
  logic             done_nxt;
  logic             entering_trig;

  sync_2ff u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_q)
  );

  // A rise only counts once echo_q has been seen low inside WAIT_RISE, so an
  // echo that is still high from a previous shot cannot start a measurement.
  assign echo_rise     = armed && echo_q;
  assign echo_fall     = echo_prev && !echo_q;
  assign entering_trig = (state_nxt == S_TRIG) && (state != S_TRIG);
  assign busy          = (state != S_IDLE);

`ifdef ULTRASONIC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_last;
  logic             timeout_nxt;
  logic             in_wait;
  logic             stay_wait;

  assign to_last   = (to_cnt == TO_LAST);
  assign in_wait   = (state == S_WAIT_RISE) || (state == S_WAIT_FALL);
  assign stay_wait = (state_nxt == S_WAIT_RISE) || (state_nxt == S_WAIT_FALL);

  // The timeout window spans both wait states, so it is only cleared when the
  // sequencer leaves the wait states, not on the WAIT_RISE -> WAIT_FALL step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt  <= (in_wait && stay_wait) ? to_cnt + 1'b1 : '0;
      timeout <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
`ifdef ULTRASONIC_TIMEOUT_EN
    timeout_nxt = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (en || start) state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (trig_cnt == TRIG_LAST) state_nxt = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
`ifdef ULTRASONIC_TIMEOUT_EN
        if (to_last) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_HOLD;
        end else
`endif
        if (echo_rise) state_nxt = S_WAIT_FALL;
      end
      S_WAIT_FALL: begin
        // A fall on the same cycle the window expires still counts as done.
        if (echo_fall) begin
          done_nxt  = 1'b1;
          state_nxt = S_HOLD;
        end
`ifdef ULTRASONIC_TIMEOUT_EN
        else if (to_last) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_HOLD;
        end
`endif
      end
      S_HOLD: begin
        // Chaining straight into TRIG keeps trig rises exactly PERIOD_CYC
        // apart while en stays high; start is deliberately not honoured here.
        if (period_cnt == PERIOD_LAST) state_nxt = en ? S_TRIG : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      trig      <= 1'b0;
      done      <= 1'b0;
      echo_prev <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      trig      <= (state_nxt == S_TRIG);
      done      <= done_nxt;
      echo_prev <= echo_q;
      armed     <= (state == S_WAIT_RISE) && (armed || !echo_q);
    end
  end

  // Pulse-width counter runs only while TRIG continues; period counter
  // measures from trig rise and saturates so HOLD can always release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_cnt   <= '0;
      period_cnt <= '0;
    end else begin
      trig_cnt <= ((state == S_TRIG) && (state_nxt == S_TRIG)) ? trig_cnt + 1'b1 : '0;
      if ((state == S_IDLE) || entering_trig) begin
        period_cnt <= '0;
      end else if (period_cnt != PERIOD_LAST) begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end

endmodule
